// File: rtl/enc_pkg.sv
// Shared constants for the switch priority-encoder front end.
// Latency: n/a (constants only).
// Backpressure: n/a (no handshake anywhere on this path).
package enc_pkg;

   localparam int N_IN   = 8;   // switch inputs; idx is 3 bits, so fixed at 8
   localparam int IDX_W  = 3;   // encoded index width
   localparam int CODE_W = 4;   // {valid, idx}

   // Code shown when encoding is disabled; decodes to a blank/zero digit.
   localparam logic [CODE_W-1:0] CODE_BLANK = 4'b0000;

endpackage

// File: rtl/debounce_bit.sv
// One switch input: 2-flop synchroniser followed by a counting debouncer.
// Latency: a level held from edge t reaches st at edge t+2+DB_CYCLES.
// Backpressure: none; free-running every cycle.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   sw_in  raw asynchronous switch level
//   st     debounced stable level
module debounce_bit import enc_pkg::*; #(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_in,
   output logic st
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      s1_d  = sw_in;
      s2_d  = s1_q;
      st_d  = st_q;
      cnt_d = cnt_q;
      if (s2_q == st_q) begin
         // Agreement restarts qualification, so any shorter glitch is lost.
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         st_d  = s2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         st_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   assign st = st_q;

endmodule

// File: rtl/sw_prio_encoder.sv
// Switch bank front end: debounce 8 switches, encode highest active as {valid,idx}.
// Latency: switch held from edge t shows on code at edge t+3+DB_CYCLES; en in 1 cycle.
// Backpressure: none; code is a level, changed pulses one cycle per new code.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   en       encode enable (synchronous); 0 forces the blank code
//   sw       raw asynchronous switch levels
//   code     registered {valid, idx}, drives the 7-segment decoder input
//   valid    code[3]
//   idx      code[2:0]
//   changed  one-cycle pulse on the edge code takes a new value
module sw_prio_encoder import enc_pkg::*; #(
   parameter int DB_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [N_IN-1:0]   sw,
   output logic [CODE_W-1:0] code,
   output logic              valid,
   output logic [IDX_W-1:0]  idx,
   output logic              changed
);

   logic [N_IN-1:0]   st;
   logic [IDX_W-1:0]  idx_c;
   logic              valid_c;
   logic [CODE_W-1:0] code_q, code_d;
   logic              changed_q, changed_d;

   for (genvar g = 0; g < N_IN; g++) begin : g_db
      debounce_bit #(
         .DB_CYCLES (DB_CYCLES)
      ) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .sw_in (sw[g]),
         .st    (st[g])
      );
   end

   // Ascending scan: the last set bit seen wins, giving bit 7 top priority.
   always_comb begin
      idx_c = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (st[i]) idx_c = IDX_W'(i);
      end
      valid_c = |st;
   end

   always_comb begin
      code_d    = en ? {valid_c, idx_c} : CODE_BLANK;
      changed_d = (code_d != code_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q    <= CODE_BLANK;
         changed_q <= 1'b0;
      end else begin
         code_q    <= code_d;
         changed_q <= changed_d;
      end
   end

   assign code    = code_q;
   assign valid   = code_q[CODE_W-1];
   assign idx     = code_q[IDX_W-1:0];
   assign changed = changed_q;

endmodule

// File: tb/tb_sw_prio_encoder.sv
module tb_sw_prio_encoder;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] sw;
   logic [3:0] code;
   logic       valid;
   logic [2:0] idx;
   logic       changed;

   int tests_run = 0;
   int tests_failed = 0;

   sw_prio_encoder #(
      .DB_CYCLES (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .sw      (sw),
      .code    (code),
      .valid   (valid),
      .idx     (idx),
      .changed (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and land 1 ns after it (sample/drive point).
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Inputs were just driven after an edge; the code must hold its old value
   // for 6 edges and switch on the 7th with a single changed pulse.
   task automatic expect_settle(input string tag, input logic [3:0] old_code,
                                input logic [3:0] new_code);
      logic bad_hold;
      bad_hold = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (code !== old_code || changed !== 1'b0) bad_hold = 1'b1;
      end
      chk({tag, "_hold"}, {31'd0, bad_hold}, 32'd0);
      tick();
      chk({tag, "_code"}, {28'd0, code}, {28'd0, new_code});
      chk({tag, "_chg"}, {31'd0, changed}, 32'd1);
      tick();
      chk({tag, "_chg_off"}, {31'd0, changed}, 32'd0);
      chk({tag, "_code_hold"}, {28'd0, code}, {28'd0, new_code});
   endtask

   initial begin
      logic seen_chg;
      logic code_moved;

      rst_n = 1'b0;
      en    = 1'b1;
      sw    = 8'hFF;

      // Reset with all switches on.
      repeat (3) tick();
      chk("rst_code", {28'd0, code}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_idx", {29'd0, idx}, 32'd0);
      chk("rst_chg", {31'd0, changed}, 32'd0);
      rst_n = 1'b1;
      expect_settle("rst_release", 4'b0000, 4'b1111);

      // Priority: bits 5 and 2, bit 5 wins.
      sw = 8'b0010_0100;
      expect_settle("prio", 4'b1111, 4'b1101);
      chk("prio_valid", {31'd0, valid}, 32'd1);
      chk("prio_idx", {29'd0, idx}, 32'd5);
      sw = 8'h00;
      expect_settle("prio_clear", 4'b1101, 4'b0000);
      chk("clear_valid", {31'd0, valid}, 32'd0);

      // Glitch on bit 3 lasting 3 cycles must be discarded.
      sw = 8'h08;
      repeat (3) tick();
      sw = 8'h00;
      seen_chg = 1'b0;
      code_moved = 1'b0;
      repeat (15) begin
         tick();
         if (changed !== 1'b0) seen_chg = 1'b1;
         if (code !== 4'b0000) code_moved = 1'b1;
      end
      chk("glitch_chg", {31'd0, seen_chg}, 32'd0);
      chk("glitch_code", {31'd0, code_moved}, 32'd0);
      sw = 8'h08;
      expect_settle("bit3", 4'b0000, 4'b1011);

      // Bit 3 releases while bit 0 asserts: both settle together.
      sw = 8'h01;
      expect_settle("swap", 4'b1011, 4'b1000);

      // Enable drop and restore.
      en = 1'b0;
      tick();
      chk("en_off_code", {28'd0, code}, 32'h0);
      chk("en_off_chg", {31'd0, changed}, 32'd1);
      tick();
      chk("en_off_chg_end", {31'd0, changed}, 32'd0);
      en = 1'b1;
      tick();
      chk("en_on_code", {28'd0, code}, 32'h8);
      chk("en_on_chg", {31'd0, changed}, 32'd1);
      tick();
      chk("en_on_chg_end", {31'd0, changed}, 32'd0);

      // Reset in the middle of bit 6 qualifying.
      sw = 8'h41;
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_code", {28'd0, code}, 32'h0);
      chk("midrst_valid", {31'd0, valid}, 32'd0);
      chk("midrst_chg", {31'd0, changed}, 32'd0);
      tick();
      rst_n = 1'b1;
      expect_settle("midrst_rel", 4'b0000, 4'b1110);

      // Stable inputs: no spurious pulses.
      seen_chg = 1'b0;
      code_moved = 1'b0;
      repeat (100) begin
         tick();
         if (changed !== 1'b0) seen_chg = 1'b1;
         if (code !== 4'b1110) code_moved = 1'b1;
      end
      chk("stable_chg", {31'd0, seen_chg}, 32'd0);
      chk("stable_code", {31'd0, code_moved}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sw_prio_encoder.md
# sw_prio_encoder

Switch-input front end for the 7-segment display path. Synchronises and debounces an 8-bit switch bank, priority-encodes the highest active switch, and registers a 4-bit code `{valid, idx[2:0]}` that drives the `b` input of the BCD-to-7-segment decoder directly. It also flags each change of the displayed code with a one-cycle pulse.

## Interface
- `N_IN`, 8: number of switch inputs; fixed at 8 for this revision, since the code is 3-bit idx plus valid.
- `DB_CYCLES`, 16: consecutive cycles a synchronised input must differ from its debounced value before the change is accepted; legal range ≥1.
- `CNT_W`, `$clog2(DB_CYCLES+1)`: debounce counter width; derived, not overridden.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  encode enable; synchronous, no synchroniser.
- `sw`  in  8  raw asynchronous switch levels.
- `code`  out  4  registered `{valid, idx}`; feeds the decoder's `b`.
- `valid`  out  1  registered; equals `code[3]`.
- `idx`  out  3  registered; equals `code[2:0]`.
- `changed`  out  1  registered one-cycle pulse when `code` takes a new value.

## Operation
- Sync: a 2-flop synchroniser per bit, `sw` → `s1` → `s2`. Reset value is 0.
- Debounce, per bit, with a counter `cnt` and a stable value `st`:
  - `s2 == st`: `cnt <= 0`.
  - `s2 != st` and `cnt == DB_CYCLES-1`: `st <= s2`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Any glitch shorter than `DB_CYCLES` cycles is discarded and the count restarts.
- Priority encode (combinational on `st`):
  - `idx_c` is the highest set bit index. Bit 7 has the highest priority.
  - `valid_c = |st`.
  - `st == 0` gives `idx_c = 0`, `valid_c = 0`.
- Output register, each cycle:
  - `en=1`: `code <= {valid_c, idx_c}`.
  - `en=0`: `code <= 4'b0000` (blank code).
- `changed <= (next code != current code)`. It is asserted for exactly one cycle per change.
- No state machine beyond the per-bit debounce counters. All counters saturate by construction, because they reset at `DB_CYCLES-1`.

## Timing
- Reset (async assert, sync release): `s1`, `s2`, `st`, `cnt` = 0; `code` = 0, `valid` = 0, `idx` = 0, `changed` = 0.
- Latency: a `sw` bit held steady from edge t reaches `st` at edge t+2+`DB_CYCLES`, and reaches `code` at edge t+3+`DB_CYCLES`. `changed` rises on that same edge.
- `en` toggle: `code` follows on the next edge (1-cycle latency). `changed` pulses if the value differs.
- Simultaneous events:
  - Several bits settling on the same edge are encoded together, with no intermediate code.
  - A higher bit releasing while a lower bit asserts is encoded per the stable vector of each cycle.
- Reset mid-debounce: pending counts are lost. After release, inputs re-qualify from `st` = 0. The full latency applies even for switches already on.
- With `DB_CYCLES=1`, a change is accepted on the first mismatching cycle.

## Structure
- Package `enc_pkg`: `N_IN` (8), `IDX_W` (3), `CODE_W` (4), and the constant `CODE_BLANK` = 4'b0000.
- Sub-module `debounce_bit`: sync pair, counter and `st` for one input, with the `DB_CYCLES` parameter. It is instantiated `N_IN` times via generate.
- Top `sw_prio_encoder`: generate loop, combinational priority encoder, output register and `changed` logic.

## Test plan
All scenarios use `DB_CYCLES=4`.
- Reset: hold `rst_n`=0 with `sw`=8'hFF, then release. `code` stays 0 for 6 edges, becomes 4'b1111 on the 7th edge, and `changed`=1 for that cycle only.
- Priority: `sw`=8'b0010_0100 stable with `en`=1 → `code`=4'b1101 (idx 5), `valid`=1. Then `sw`=0 → `code`=4'b0000 seven edges later.
- Glitch reject: `sw[3]` high for 3 cycles, then low → `code` unchanged, `changed` never asserts. High for 4+ cycles → `code`=4'b1011 at t+7.
- Enable: stable `sw`=8'h01 with `code`=4'b1000; drop `en` → `code`=4'b0000 next edge with a `changed` pulse. Raise `en` → `code`=4'b1000 next edge with a `changed` pulse.
- Reset mid-debounce: `sw[6]` rises, then `rst_n` pulses low at t+4 → all outputs 0 immediately. After release, `code`=4'b1110 only after 7 further edges.
- No spurious pulse: `sw` constant for 100 cycles after settling → `changed`=0 throughout, `code` constant.
